// File: rtl/udp_rx_stream.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// udp_rx_stream
//
// Purpose
//   Receives Ethernet/IPv4/UDP frames on a 64-bit AXI-Stream input, checks
//   the 42-byte header (Ethernet 14 B, IPv4 20 B without options, UDP 8 B),
//   and forwards only the UDP payload on a 64-bit AXI-Stream output.
//   The output is realigned so that payload byte 0 lands in tdata[7:0].
//   Frames that fail the header check, and runts that end before the header
//   is complete, are discarded and counted.
//
// Ports
//   s00_axis_aclk       sole clock
//   s00_axis_aresetn    synchronous active-low reset
//   s00_axis_t*         input frame stream (byte 0 in [7:0]; tuser = frame
//                       error, sampled on the tlast beat)
//   m00_axis_t*         output payload stream (tuser only on the tlast beat)
//   cfg_dst_port        required UDP destination port (sampled at beat 4)
//   cfg_dst_ip          required IPv4 destination (sampled at beat 4, only
//                       used when UDP_RX_IP_FILTER_EN is defined)
//   good_pkt_cnt        frames forwarded (wraps)
//   drop_pkt_cnt        frames discarded (wraps)
//
// Build option
//   UDP_RX_IP_FILTER_EN  when defined, the IPv4 destination address must also
//                        match cfg_dst_ip; otherwise cfg_dst_ip is ignored.
// ---------------------------------------------------------------------------
module udp_rx_stream #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tkeep,
    input  logic                                s00_axis_tvalid,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tuser,
    output logic                                s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tkeep,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic                                m00_axis_tuser,
    input  logic                                m00_axis_tready,
    input  logic [15:0]                         cfg_dst_port,
    input  logic [31:0]                         cfg_dst_ip,
    output logic [31:0]                         good_pkt_cnt,
    output logic [31:0]                         drop_pkt_cnt
);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t       state_q,      state_d;
    logic [2:0]   beat_cnt_q,   beat_cnt_d;     // header beat index, HDR only
    logic         hdr_ok_q,     hdr_ok_d;       // running result of beat 1/2 checks
    logic [47:0]  residue_q,    residue_d;      // bytes 2-7 of previous beat
    logic [7:0]   flush_keep_q, flush_keep_d;   // keep of the trailing FLUSH beat
    logic         flush_user_q, flush_user_d;
    logic         m_valid_q,    m_valid_d;
    logic [63:0]  m_data_q,     m_data_d;
    logic [7:0]   m_keep_q,     m_keep_d;
    logic         m_last_q,     m_last_d;
    logic         m_user_q,     m_user_d;
    logic [31:0]  good_cnt_q,   good_cnt_d;
    logic [31:0]  drop_cnt_q,   drop_cnt_d;
`ifdef UDP_RX_IP_FILTER_EN
    logic [15:0]  ip_hi_q,      ip_hi_d;        // beat 3 bytes 6-7 (dst IP MSBs)
`endif

    // ------------------------------------------------------------------
    // Input view and handshake
    // ------------------------------------------------------------------
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        s_ready;
    logic        s_fire;
    logic        out_free;

    assign in_data  = s00_axis_tdata;
    assign in_keep  = s00_axis_tkeep;

    // The output register may take a new beat when it is empty or draining.
    assign out_free = !m_valid_q || m00_axis_tready;

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            // Beat 5 may emit a short final beat, so it must not overwrite a
            // beat of the previous frame still stalled in the output register.
            ST_HDR:     s_ready = (beat_cnt_q == 3'd5) ? out_free : 1'b1;
            ST_PAYLOAD: s_ready = out_free;
            ST_FLUSH:   s_ready = 1'b0;
            ST_DROP:    s_ready = 1'b1;
            default:    s_ready = 1'b0;
        endcase
    end

    assign s00_axis_tready = s00_axis_aresetn & s_ready;
    assign s_fire          = s00_axis_tvalid & s00_axis_tready;

    // ------------------------------------------------------------------
    // Header field checks (each valid only on its own header beat)
    // ------------------------------------------------------------------
    logic eth_ok;      // beat 1: ethertype 0x0800, IPv4 version/IHL 0x45
    logic proto_ok;    // beat 2: IP protocol UDP
    logic port_ok;     // beat 4: UDP destination port
    logic ip_ok;       // beat 4: IPv4 destination (optional)

    assign eth_ok   = (in_data[39:32] == 8'h08) && (in_data[47:40] == 8'h00) &&
                      (in_data[55:48] == 8'h45);
    assign proto_ok = (in_data[63:56] == 8'h11);
    assign port_ok  = ({in_data[39:32], in_data[47:40]} == cfg_dst_port);

`ifdef UDP_RX_IP_FILTER_EN
    assign ip_ok = ({ip_hi_q, in_data[7:0], in_data[15:8]} == cfg_dst_ip);
`else
    logic unused_cfg_ip;
    assign ip_ok         = 1'b1;
    assign unused_cfg_ip = ^cfg_dst_ip;
`endif

    // A tlast beat carrying fewer than 2 bytes at beat 5 still leaves the
    // header incomplete, so it is treated like any earlier runt.
    logic runt_end;
    assign runt_end = s00_axis_tlast &&
                      ((beat_cnt_q != 3'd5) || !in_keep[1]);

    // ------------------------------------------------------------------
    // Next-state logic; emits one candidate output beat via ld_*
    // ------------------------------------------------------------------
    logic        load;
    logic [63:0] ld_data;
    logic [7:0]  ld_keep;
    logic        ld_last;
    logic        ld_user;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        hdr_ok_d     = hdr_ok_q;
        residue_d    = residue_q;
        flush_keep_d = flush_keep_q;
        flush_user_d = flush_user_q;
        good_cnt_d   = good_cnt_q;
        drop_cnt_d   = drop_cnt_q;
`ifdef UDP_RX_IP_FILTER_EN
        ip_hi_d      = ip_hi_q;
`endif
        load         = 1'b0;
        ld_data      = 64'h0;
        ld_keep      = 8'h00;
        ld_last      = 1'b0;
        ld_user      = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (s_fire) begin
                    if (runt_end) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        beat_cnt_d = 3'd0;
                    end else begin
                        case (beat_cnt_q)
                            3'd0: begin
                                hdr_ok_d   = 1'b1;
                                beat_cnt_d = 3'd1;
                            end
                            3'd1: begin
                                hdr_ok_d   = eth_ok;
                                beat_cnt_d = 3'd2;
                            end
                            3'd2: begin
                                hdr_ok_d   = hdr_ok_q & proto_ok;
                                beat_cnt_d = 3'd3;
                            end
                            3'd3: begin
`ifdef UDP_RX_IP_FILTER_EN
                                ip_hi_d    = {in_data[55:48], in_data[63:56]};
`endif
                                beat_cnt_d = 3'd4;
                            end
                            3'd4: begin
                                if (hdr_ok_q && port_ok && ip_ok) begin
                                    beat_cnt_d = 3'd5;
                                end else begin
                                    state_d    = ST_DROP;
                                    beat_cnt_d = 3'd0;
                                end
                            end
                            default: begin
                                // Beat 5: bytes 0-1 end the UDP header,
                                // bytes 2-7 are the first payload bytes.
                                residue_d  = in_data[63:16];
                                beat_cnt_d = 3'd0;
                                if (s00_axis_tlast) begin
                                    good_cnt_d = good_cnt_q + 32'd1;
                                    if (in_keep[2]) begin
                                        load    = 1'b1;
                                        ld_data = {16'h0, in_data[63:16]};
                                        ld_keep = {2'b00, in_keep[7:2]};
                                        ld_last = 1'b1;
                                        ld_user = s00_axis_tuser;
                                    end
                                end else begin
                                    state_d = ST_PAYLOAD;
                                end
                            end
                        endcase
                    end
                end
            end

            ST_PAYLOAD: begin
                if (s_fire) begin
                    load      = 1'b1;
                    ld_data   = {in_data[15:0], residue_q};
                    ld_keep   = 8'hFF;
                    residue_d = in_data[63:16];
                    if (s00_axis_tlast) begin
                        if (in_keep[2]) begin
                            // More than 2 bytes: the remainder needs a
                            // second beat, emitted from FLUSH.
                            state_d      = ST_FLUSH;
                            flush_keep_d = {2'b00, in_keep[7:2]};
                            flush_user_d = s00_axis_tuser;
                        end else begin
                            ld_keep    = {in_keep[1:0], 6'h3F};
                            ld_last    = 1'b1;
                            ld_user    = s00_axis_tuser;
                            good_cnt_d = good_cnt_q + 32'd1;
                            state_d    = ST_HDR;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                if (out_free) begin
                    load       = 1'b1;
                    ld_data    = {16'h0, residue_q};
                    ld_keep    = flush_keep_q;
                    ld_last    = 1'b1;
                    ld_user    = flush_user_q;
                    good_cnt_d = good_cnt_q + 32'd1;
                    state_d    = ST_HDR;
                end
            end

            ST_DROP: begin
                if (s_fire && s00_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = ST_HDR;
                end
            end

            default: begin
                state_d    = ST_HDR;
                beat_cnt_d = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: bytes outside tkeep are forced to zero so that the
    // stream content is fully deterministic.
    // ------------------------------------------------------------------
    logic [63:0] ld_mask;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte_mask
            assign ld_mask[gi*8 +: 8] = {8{ld_keep[gi]}};
        end
    endgenerate

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        if (out_free) begin
            m_valid_d = load;
            if (load) begin
                m_data_d = ld_data & ld_mask;
                m_keep_d = ld_keep;
                m_last_d = ld_last;
                m_user_d = ld_last & ld_user;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q      <= ST_HDR;
            beat_cnt_q   <= 3'd0;
            hdr_ok_q     <= 1'b0;
            residue_q    <= 48'h0;
            flush_keep_q <= 8'h00;
            flush_user_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= 64'h0;
            m_keep_q     <= 8'h00;
            m_last_q     <= 1'b0;
            m_user_q     <= 1'b0;
            good_cnt_q   <= 32'h0;
            drop_cnt_q   <= 32'h0;
`ifdef UDP_RX_IP_FILTER_EN
            ip_hi_q      <= 16'h0;
`endif
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            hdr_ok_q     <= hdr_ok_d;
            residue_q    <= residue_d;
            flush_keep_q <= flush_keep_d;
            flush_user_q <= flush_user_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
            good_cnt_q   <= good_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef UDP_RX_IP_FILTER_EN
            ip_hi_q      <= ip_hi_d;
`endif
        end
    end

    assign m00_axis_tvalid = m_valid_q;
    assign m00_axis_tdata  = m_data_q;
    assign m00_axis_tkeep  = m_keep_q;
    assign m00_axis_tlast  = m_last_q;
    assign m00_axis_tuser  = m_user_q;
    assign good_pkt_cnt    = good_cnt_q;
    assign drop_pkt_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_stream.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_udp_rx_stream
//
// Drives whole Ethernet/IPv4/UDP frames (directed and random) into
// udp_rx_stream. A reference model works on the frame as a byte list: it
// decides pass/drop from the header bytes, then cuts the payload into 8-byte
// output beats. Output beats, counters and output stability under
// back-pressure are compared against the model.
// ---------------------------------------------------------------------------
module tb_udp_rx_stream;

    typedef logic [7:0] u8;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tuser, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tuser, m_tready;
    logic [15:0] cfg_dst_port;
    logic [31:0] cfg_dst_ip;
    logic [31:0] good_cnt, drop_cnt;

    always #5 clk = ~clk;

    udp_rx_stream dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tkeep   (s_tkeep),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tuser   (s_tuser),
        .s00_axis_tready  (s_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tkeep   (m_tkeep),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tuser   (m_tuser),
        .m00_axis_tready  (m_tready),
        .cfg_dst_port     (cfg_dst_port),
        .cfg_dst_ip       (cfg_dst_ip),
        .good_pkt_cnt     (good_cnt),
        .drop_pkt_cnt     (drop_cnt)
    );

    // Bookkeeping
    int           n_cmp = 0;
    int           n_bad = 0;
    beat_t        got_q[$];
    beat_t        exp_q[$];
    logic [149:0] stall_q[$];
    int           rd_ptr = 0;
    int           st_ptr = 0;
    int           win_zero = 0;
    logic         win_en = 1'b0;
    logic         throttle = 1'b0;
    u8            frm[$];
    logic [15:0]  cfg_port_model;
    logic [31:0]  cfg_ip_model;
    int           exp_good = 0;
    int           exp_drop = 0;

    // Downstream ready: constant 1, or toggling every cycle when throttled.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = throttle ? ~m_tready : 1'b1;
        end
    end

    // Output monitor, sampled on the falling edge.
    logic [74:0] prev_word  = '0;
    logic        prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n && prev_stall)
            stall_q.push_back({prev_word, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser});
        if (rst_n && m_tvalid && m_tready)
            got_q.push_back({m_tdata, m_tkeep, m_tlast, m_tuser});
        if (win_en && rst_n && !s_tready)
            win_zero <= win_zero + 1;
        prev_word  <= {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser};
        prev_stall <= rst_n && m_tvalid && !m_tready;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- frame construction ----------------
    task automatic make_frame(input int plen, input logic [15:0] port,
                              input logic [31:0] ip, input int corrupt);
        frm.delete();
        for (int i = 0; i < 42 + plen; i++) frm.push_back(u8'($urandom_range(0, 255)));
        frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45; frm[23] = 8'h11;
        frm[30] = ip[31:24]; frm[31] = ip[23:16]; frm[32] = ip[15:8]; frm[33] = ip[7:0];
        frm[36] = port[15:8]; frm[37] = port[7:0];
        case (corrupt)
            1: frm[12] = 8'h86;
            2: frm[13] = 8'hDD;
            3: frm[14] = 8'h46;
            4: frm[23] = 8'h06;
            5: frm[37] = port[7:0] ^ 8'h01;
            default: ;
        endcase
    endtask

    task automatic make_runt(input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(u8'($urandom_range(0, 255)));
    endtask

    // ---------------- reference model ----------------
    task automatic model_frame(input logic user);
        int    len;
        int    p;
        int    n;
        logic  pass;
        beat_t b;
        len = frm.size();
        if (len < 42) begin
            exp_drop++;
            return;
        end
        pass = (frm[12] == 8'h08) && (frm[13] == 8'h00) && (frm[14] == 8'h45) &&
               (frm[23] == 8'h11) && ({frm[36], frm[37]} == cfg_port_model);
`ifdef UDP_RX_IP_FILTER_EN
        pass = pass && ({frm[30], frm[31], frm[32], frm[33]} == cfg_ip_model);
`endif
        if (!pass) begin
            exp_drop++;
            return;
        end
        exp_good++;
        p = len - 42;
        for (int off = 0; off < p; off += 8) begin
            n = (p - off > 8) ? 8 : p - off;
            b.data = '0;
            for (int j = 0; j < n; j++) b.data[j*8 +: 8] = frm[42 + off + j];
            b.keep = 8'((1 << n) - 1);
            b.last = (off + 8 >= p);
            b.user = b.last ? user : 1'b0;
            exp_q.push_back(b);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic l, input logic u);
        int waitc;
        waitc    = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        while (!s_tready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!s_tready) check("accept_timeout", s_tready, 1'b1);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic user, input int max_beats, input int chg_beat);
        int          len;
        int          nb;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        len = frm.size();
        nb  = (len + 7) / 8;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < len) begin
                    d[j*8 +: 8] = frm[b * 8 + j];
                    k[j] = 1'b1;
                end
            end
            l = (b == nb - 1);
            if (b == chg_beat) cfg_dst_port = ~cfg_port_model;
            drive_beat(d, k, l, l ? user : 1'b0);
        end
        s_tvalid     = 1'b0;
        s_tlast      = 1'b0;
        s_tuser      = 1'b0;
        s_tkeep      = 8'h00;
        s_tdata      = 64'h0;
        cfg_dst_port = cfg_port_model;
    endtask

    task automatic finish_frame(input string tag);
        int w;
        int got_n;
        w = 0;
        while (((got_q.size() - rd_ptr) < exp_q.size() || m_tvalid) && w < 400) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_drain"}, (w < 400), 1'b1);
        repeat (4) @(negedge clk);
        got_n = got_q.size() - rd_ptr;
        check({tag, "_beats"}, got_n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (rd_ptr + i < got_q.size())
                check({tag, "_beat"}, got_q[rd_ptr + i], exp_q[i]);
        check({tag, "_good"}, good_cnt, exp_good);
        check({tag, "_drop"}, drop_cnt, exp_drop);
        while (st_ptr < stall_q.size()) begin
            check({tag, "_stall"}, stall_q[st_ptr][149:75], stall_q[st_ptr][74:0]);
            st_ptr++;
        end
        $display("frame %-14s len=%0d out_beats=%0d exp_beats=%0d good=%0d drop=%0d",
                 tag, frm.size(), got_n, exp_q.size(), good_cnt, drop_cnt);
        rd_ptr = got_q.size();
        exp_q.delete();
    endtask

    task automatic run_cur(input string tag, input logic user);
        model_frame(user);
        send_frame(user, 1000, -1);
        finish_frame(tag);
    endtask

    task automatic run_frame(input string tag, input int plen, input logic [15:0] port,
                             input logic [31:0] ip, input int corrupt, input logic user);
        make_frame(plen, port, ip, corrupt);
        run_cur(tag, user);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int win_start;
        int r;
        rst_n          = 1'b0;
        s_tdata        = 64'h0;
        s_tkeep        = 8'h00;
        s_tvalid       = 1'b0;
        s_tlast        = 1'b0;
        s_tuser        = 1'b0;
        cfg_port_model = 16'd5000;
        cfg_ip_model   = 32'hC0A80002;
        cfg_dst_port   = cfg_port_model;
        cfg_dst_ip     = cfg_ip_model;

        repeat (3) @(negedge clk);
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tlast",  m_tlast,  1'b0);
        check("rst_tuser",  m_tuser,  1'b0);
        check("rst_tdata",  m_tdata,  64'h0);
        check("rst_tkeep",  m_tkeep,  8'h00);
        check("rst_tready", s_tready, 1'b0);
        check("rst_good",   good_cnt, 32'h0);
        check("rst_drop",   drop_cnt, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 64 B payload: 8 full beats, no input stall.
        make_frame(64, 16'd5000, 32'hC0A80002, 0);
        win_start = win_zero;
        win_en = 1'b1;
        run_cur("p64", 1'b0);
        win_en = 1'b0;
        check("p64_tready_low", win_zero - win_start, 0);

        // Same frame with downstream ready toggling: same expected data.
        throttle = 1'b1;
        run_cur("p64_throttle", 1'b0);
        throttle = 1'b0;
        repeat (2) @(negedge clk);

        // 67 B payload: 9 beats, input held off for exactly the FLUSH cycle.
        make_frame(67, 16'd5000, 32'hC0A80002, 0);
        win_start = win_zero;
        win_en = 1'b1;
        run_cur("p67", 1'b0);
        win_en = 1'b0;
        check("p67_tready_low", win_zero - win_start, 1);

        run_frame("port5001",    64, 16'd5001, 32'hC0A80002, 0, 1'b0);
        run_frame("after_drop",  64, 16'd5000, 32'hC0A80002, 0, 1'b0);
        make_runt(24);
        run_cur("runt3", 1'b0);
        run_frame("tuser",       40, 16'd5000, 32'hC0A80002, 0, 1'b1);
        run_frame("ip_mismatch", 32, 16'd5000, 32'hC0A80003, 0, 1'b0);

        // Short payloads around the beat-5 / beat-6 boundaries.
        run_frame("plen0",  0,  16'd5000, 32'hC0A80002, 0, 1'b1);
        run_frame("plen1",  1,  16'd5000, 32'hC0A80002, 0, 1'b0);
        run_frame("plen3",  3,  16'd5000, 32'hC0A80002, 0, 1'b1);
        run_frame("plen6",  6,  16'd5000, 32'hC0A80002, 0, 1'b0);
        run_frame("plen7",  7,  16'd5000, 32'hC0A80002, 0, 1'b1);
        run_frame("plen8",  8,  16'd5000, 32'hC0A80002, 0, 1'b0);
        run_frame("plen15", 15, 16'd5000, 32'hC0A80002, 0, 1'b1);
        make_runt(40);
        run_cur("runt40", 1'b0);

        // Each header field wrong in turn.
        for (int c = 1; c <= 4; c++)
            run_frame($sformatf("bad_hdr%0d", c), 20, 16'd5000, 32'hC0A80002, c, 1'b0);

        // Port changed after beat 4: the frame in flight is unaffected.
        make_frame(50, 16'd5000, 32'hC0A80002, 0);
        model_frame(1'b0);
        send_frame(1'b0, 1000, 6);
        finish_frame("cfg_mid");

        // Reset in the middle of a frame, then a fresh frame.
        make_frame(100, 16'd5000, 32'hC0A80002, 0);
        send_frame(1'b0, 8, -1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_tvalid", m_tvalid, 1'b0);
        check("midrst_good",   good_cnt, 32'h0);
        check("midrst_drop",   drop_cnt, 32'h0);
        rst_n = 1'b1;
        exp_good = 0;
        exp_drop = 0;
        exp_q.delete();
        rd_ptr = got_q.size();
        @(negedge clk);
        run_frame("post_rst", 30, 16'd5000, 32'hC0A80002, 0, 1'b0);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            throttle = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r == 0) begin
                make_runt($urandom_range(1, 40));
            end else begin
                make_frame($urandom_range(0, 120), cfg_port_model,
                           ($urandom_range(0, 3) == 0) ? 32'hC0A80003 : cfg_ip_model,
                           (r == 1) ? $urandom_range(1, 5) : 0);
            end
            run_cur($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
        end
        throttle = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
